// File: rtl/cpu6_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cpu6_pkg
//  Description : Shared encodings for the 6-bit CPU control path: opcodes,
//                controller states, bus mux selects and the EXEC-cycle
//                strobe decode used by the control unit.
//  Revision    : 1.0 - initial release
// ============================================================================
package cpu6_pkg;

    // Opcode field, instr[5:3]
    localparam logic [2:0] OP_NOP = 3'b000;
    localparam logic [2:0] OP_LDI = 3'b001;
    localparam logic [2:0] OP_LDR = 3'b010;
    localparam logic [2:0] OP_ADD = 3'b011;
    localparam logic [2:0] OP_SUB = 3'b100;
    localparam logic [2:0] OP_JMP = 3'b101;
    localparam logic [2:0] OP_JZ  = 3'b110;
    localparam logic [2:0] OP_HLT = 3'b111;

    // Downstream 4:1 bus mux selects
    localparam logic [1:0] BUS_ALU = 2'b00;
    localparam logic [1:0] BUS_REG = 2'b01;
    localparam logic [1:0] BUS_IMM = 2'b10;
    localparam logic [1:0] BUS_MEM = 2'b11;

    // Controller state encodings
    localparam logic [2:0] S_FETCH  = 3'd0;
    localparam logic [2:0] S_DECODE = 3'd1;
    localparam logic [2:0] S_EXEC   = 3'd2;
    localparam logic [2:0] S_HALT   = 3'd3;
    localparam logic [2:0] S_FAULT  = 3'd4;

    typedef enum logic [2:0] {
        ST_FETCH  = S_FETCH,
        ST_DECODE = S_DECODE,
        ST_EXEC   = S_EXEC,
        ST_HALT   = S_HALT,
        ST_FAULT  = S_FAULT
    } state_t;

    // Strobes the EXEC cycle can raise
    typedef struct packed {
        logic [1:0] bus_sel;
        logic       pc_load;
        logic       acc_load;
        logic       flags_load;
        logic       alu_op;
    } exec_ctrl_t;

    // Per-opcode EXEC strobes; JZ only jumps when the zero flag is set.
    // NOP and HLT raise nothing (HLT never reaches EXEC anyway).
    function automatic exec_ctrl_t exec_decode(input logic [2:0] op,
                                               input logic       zf);
        exec_ctrl_t c;
        c = '0;
        c.bus_sel = BUS_ALU;
        case (op)
            OP_LDI: begin
                c.bus_sel  = BUS_IMM;
                c.acc_load = 1'b1;
            end
            OP_LDR: begin
                c.bus_sel  = BUS_REG;
                c.acc_load = 1'b1;
            end
            OP_ADD: begin
                c.bus_sel    = BUS_ALU;
                c.alu_op     = 1'b0;
                c.acc_load   = 1'b1;
                c.flags_load = 1'b1;
            end
            OP_SUB: begin
                c.bus_sel    = BUS_ALU;
                c.alu_op     = 1'b1;
                c.acc_load   = 1'b1;
                c.flags_load = 1'b1;
            end
            OP_JMP: begin
                c.bus_sel = BUS_IMM;
                c.pc_load = 1'b1;
            end
            OP_JZ: begin
                if (zf) begin
                    c.bus_sel = BUS_IMM;
                    c.pc_load = 1'b1;
                end
            end
            default: begin
                c = '0;
            end
        endcase
        return c;
    endfunction

endpackage
`default_nettype wire

// File: rtl/control_fetch_timer.sv
`default_nettype none
// ============================================================================
//  Module      : control_fetch_timer
//  Description : Counts consecutive FETCH cycles without memory data and
//                flags when the count has reached TIMEOUT-1, i.e. the current
//                cycle is the last one allowed before a fault.
//  Revision    : 1.0 - initial release
// ============================================================================
module control_fetch_timer #(
    parameter int TIMEOUT = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam logic [5:0] C_LIMIT = 6'(TIMEOUT - 1);

    logic [5:0] r_count;

    // Wait counter: clear has priority so a completed fetch restarts from 0
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= 6'd0;
        end else if (clear) begin
            r_count <= 6'd0;
        end else if (enable) begin
            r_count <= r_count + 6'd1;
        end
    end

    // Expired while the counter sits on the final permitted wait cycle
    always_comb begin
        expired = (r_count == C_LIMIT);
    end

endmodule
`default_nettype wire

// File: rtl/control_unit_6_bit.sv
`default_nettype none
// ============================================================================
//  Module      : control_unit_6_bit
//  Description : Multi-cycle controller for a 6-bit accumulator CPU.
//                FETCH -> DECODE -> EXEC loop with a bounded fetch wait,
//                sticky HALT and FAULT states, and a retired-instruction
//                counter.
//  Revision    : 1.0 - initial release
// ============================================================================
module control_unit_6_bit
    import cpu6_pkg::*;
#(
    parameter int FETCH_TIMEOUT = 15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] instr,
    input  logic       mem_ready,
    input  logic       zero_flag,
    output logic [1:0] bus_sel,
    output logic       mem_req,
    output logic       ir_load,
    output logic       pc_inc,
    output logic       pc_load,
    output logic       acc_load,
    output logic       flags_load,
    output logic       alu_op,
    output logic [2:0] reg_addr,
    output logic       halted,
    output logic       fault,
    output logic [5:0] instr_count
);

    state_t     r_state;
    state_t     w_next;
    logic [5:0] r_ir;
    logic [5:0] r_instr_count;
    logic       w_in_fetch;
    logic       w_timer_clear;
    logic       w_timer_enable;
    logic       w_timer_expired;
    exec_ctrl_t w_exec;

    // Timer runs only while FETCH is stalled; anything else zeroes it
    always_comb begin
        w_in_fetch     = (r_state == ST_FETCH);
        w_timer_enable = w_in_fetch & ~mem_ready;
        w_timer_clear  = ~w_in_fetch | mem_ready;
    end

    control_fetch_timer #(
        .TIMEOUT (FETCH_TIMEOUT)
    ) u_fetch_timer (
        .clk     (clk),
        .rst     (rst),
        .clear   (w_timer_clear),
        .enable  (w_timer_enable),
        .expired (w_timer_expired)
    );

    // Next-state logic; a ready fetch beats the timeout in the same cycle
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_FETCH: begin
                if (mem_ready) begin
                    w_next = ST_DECODE;
                end else if (w_timer_expired) begin
                    w_next = ST_FAULT;
                end
            end
            ST_DECODE: begin
                w_next = (r_ir[5:3] == OP_HLT) ? ST_HALT : ST_EXEC;
            end
            ST_EXEC: begin
                w_next = ST_FETCH;
            end
            ST_HALT: begin
                w_next = ST_HALT;
            end
            ST_FAULT: begin
                w_next = ST_FAULT;
            end
            default: begin
                w_next = ST_FAULT;
            end
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_FETCH;
        end else begin
            r_state <= w_next;
        end
    end

    // Instruction register captures the bus when a fetch completes
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ir <= 6'd0;
        end else if (w_in_fetch && mem_ready) begin
            r_ir <= instr;
        end
    end

    // Retired counter: every EXEC cycle returns to FETCH, so count on EXEC
    always_ff @(posedge clk) begin
        if (rst) begin
            r_instr_count <= 6'd0;
        end else if (r_state == ST_EXEC) begin
            r_instr_count <= r_instr_count + 6'd1;
        end
    end

    // Opcode strobes for the EXEC cycle, zero flag sampled live
    always_comb begin
        w_exec = exec_decode(r_ir[5:3], zero_flag);
    end

    // Output decode: everything quiet unless FETCH or EXEC says otherwise
    always_comb begin
        bus_sel     = BUS_ALU;
        mem_req     = 1'b0;
        ir_load     = 1'b0;
        pc_inc      = 1'b0;
        pc_load     = 1'b0;
        acc_load    = 1'b0;
        flags_load  = 1'b0;
        alu_op      = 1'b0;
        reg_addr    = r_ir[2:0];
        halted      = (r_state == ST_HALT);
        fault       = (r_state == ST_FAULT);
        instr_count = r_instr_count;
        case (r_state)
            ST_FETCH: begin
                mem_req = 1'b1;
                bus_sel = BUS_MEM;
                ir_load = mem_ready;
                pc_inc  = mem_ready;
            end
            ST_EXEC: begin
                bus_sel    = w_exec.bus_sel;
                pc_load    = w_exec.pc_load;
                acc_load   = w_exec.acc_load;
                flags_load = w_exec.flags_load;
                alu_op     = w_exec.alu_op;
            end
            default: begin
                bus_sel = BUS_ALU;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_control_unit_6_bit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_control_unit_6_bit
//  Description : Scoreboard bench for control_unit_6_bit. Stimulus pushes the
//                hand-derived output vector for each cycle; a monitor on the
//                falling edge pops and compares against the DUT.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_control_unit_6_bit;

    logic       clk;
    logic       rst;
    logic [5:0] instr;
    logic       mem_ready;
    logic       zero_flag;
    logic [1:0] bus_sel;
    logic       mem_req;
    logic       ir_load;
    logic       pc_inc;
    logic       pc_load;
    logic       acc_load;
    logic       flags_load;
    logic       alu_op;
    logic [2:0] reg_addr;
    logic       halted;
    logic       fault;
    logic [5:0] instr_count;

    int total = 0;
    int bad   = 0;

    logic [19:0] exp_q[$];
    string       name_q[$];

    // Model of the two pieces of state visible on the outputs
    logic [5:0] m_cnt;
    logic [2:0] m_ra;

    control_unit_6_bit #(
        .FETCH_TIMEOUT (4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .instr       (instr),
        .mem_ready   (mem_ready),
        .zero_flag   (zero_flag),
        .bus_sel     (bus_sel),
        .mem_req     (mem_req),
        .ir_load     (ir_load),
        .pc_inc      (pc_inc),
        .pc_load     (pc_load),
        .acc_load    (acc_load),
        .flags_load  (flags_load),
        .alu_op      (alu_op),
        .reg_addr    (reg_addr),
        .halted      (halted),
        .fault       (fault),
        .instr_count (instr_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {bus_sel, mem_req, ir_load, pc_inc, pc_load, acc_load, flags_load,
    //  alu_op, reg_addr, halted, fault, instr_count}
    function automatic logic [19:0] ev(input logic [1:0] bs, input logic mr,
                                       input logic il, input logic pi,
                                       input logic pl, input logic al,
                                       input logic fl, input logic ao,
                                       input logic [2:0] ra, input logic h,
                                       input logic f, input logic [5:0] cnt);
        return {bs, mr, il, pi, pl, al, fl, ao, ra, h, f, cnt};
    endfunction

    // Monitor: one expected vector per checked cycle
    always @(negedge clk) begin
        logic [19:0] act;
        logic [19:0] exp_v;
        string       nm;
        if (exp_q.size() > 0) begin
            exp_v = exp_q.pop_front();
            nm    = name_q.pop_front();
            act   = {bus_sel, mem_req, ir_load, pc_inc, pc_load, acc_load,
                     flags_load, alu_op, reg_addr, halted, fault, instr_count};
            total++;
            if (act !== exp_v) begin
                bad++;
                $display("FAIL %s: got %b required %b", nm, act, exp_v);
            end
        end
    end

    task automatic step(input logic [5:0] ins, input logic rdy, input logic zf,
                        input logic [19:0] exp_v, input string nm);
        @(posedge clk);
        #1;
        rst       = 1'b0;
        instr     = ins;
        mem_ready = rdy;
        zero_flag = zf;
        exp_q.push_back(exp_v);
        name_q.push_back(nm);
    endtask

    task automatic pulse_reset;
        @(posedge clk);
        #1;
        rst       = 1'b1;
        mem_ready = 1'b0;
        m_cnt     = 6'd0;
        m_ra      = 3'd0;
    endtask

    task automatic fetch_wait(input string nm);
        step(6'h2A, 1'b0, 1'b0, ev(2'b11, 1, 0, 0, 0, 0, 0, 0, m_ra, 0, 0, m_cnt), nm);
    endtask

    // Full FETCH/DECODE/EXEC with hand-chosen EXEC strobes. Non-FETCH cycles
    // drive garbage on instr with mem_ready high to expose leakage.
    task automatic run(input logic [5:0] ins, input logic zf, input logic [1:0] bs,
                       input logic pl, input logic al, input logic fl,
                       input logic ao, input string nm);
        step(ins, 1'b1, ~zf, ev(2'b11, 1, 1, 1, 0, 0, 0, 0, m_ra, 0, 0, m_cnt),
             {nm, "/fetch"});
        m_ra = ins[2:0];
        step(~ins, 1'b1, ~zf, ev(2'b00, 0, 0, 0, 0, 0, 0, 0, m_ra, 0, 0, m_cnt),
             {nm, "/decode"});
        step(~ins, 1'b1, zf, ev(bs, 0, 0, 0, pl, al, fl, ao, m_ra, 0, 0, m_cnt),
             {nm, "/exec"});
        m_cnt = m_cnt + 6'd1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b1;
        instr     = 6'd0;
        mem_ready = 1'b0;
        zero_flag = 1'b0;
        m_cnt     = 6'd0;
        m_ra      = 3'd0;
        repeat (2) @(posedge clk);

        // Opcode coverage
        run(6'b001_101, 1'b0, 2'b10, 0, 1, 0, 0, "ldi5");
        run(6'b110_011, 1'b0, 2'b00, 0, 0, 0, 0, "jz_not_taken");
        run(6'b110_011, 1'b1, 2'b10, 1, 0, 0, 0, "jz_taken");
        run(6'b011_010, 1'b0, 2'b00, 0, 1, 1, 0, "add");
        run(6'b100_001, 1'b1, 2'b00, 0, 1, 1, 1, "sub");
        run(6'b010_110, 1'b0, 2'b01, 0, 1, 0, 0, "ldr");
        run(6'b101_111, 1'b0, 2'b10, 1, 0, 0, 0, "jmp");

        // Ready on the 4th (final) wait cycle still completes the fetch
        repeat (3) fetch_wait("wait3");
        run(6'b000_100, 1'b0, 2'b00, 0, 0, 0, 0, "nop_ready_on_4th");

        // Four stalled cycles -> FAULT, sticky even with mem_ready high
        repeat (4) fetch_wait("wait_to_fault");
        repeat (3) step(6'b001_001, 1'b1, 1'b1,
                        ev(2'b00, 0, 0, 0, 0, 0, 0, 0, m_ra, 0, 1, m_cnt), "fault");

        // Reset out of FAULT
        pulse_reset();
        fetch_wait("post_fault_reset");

        // Reset mid-wait clears the wait counter
        fetch_wait("mid_wait");
        pulse_reset();
        repeat (3) fetch_wait("after_wait_reset");
        run(6'b001_010, 1'b0, 2'b10, 0, 1, 0, 0, "ldi2_after_reset");

        // 64 NOPs: counter wraps 63 -> 0
        pulse_reset();
        for (int i = 0; i < 64; i++) begin
            run({3'b000, 3'(i)}, 1'b0, 2'b00, 0, 0, 0, 0, "nop64");
        end
        step(6'h2A, 1'b0, 1'b0, ev(2'b11, 1, 0, 0, 0, 0, 0, 0, 3'd7, 0, 0, 6'd0), "wrap");

        // HLT: halted the cycle after DECODE, count frozen, quiet 10 more cycles
        run(6'b011_011, 1'b0, 2'b00, 0, 1, 1, 0, "add_before_hlt");
        step(6'b111_000, 1'b1, 1'b0, ev(2'b11, 1, 1, 1, 0, 0, 0, 0, m_ra, 0, 0, m_cnt),
             "hlt/fetch");
        m_ra = 3'd0;
        step(6'b000_111, 1'b1, 1'b1, ev(2'b00, 0, 0, 0, 0, 0, 0, 0, 3'd0, 0, 0, 6'd1),
             "hlt/decode");
        repeat (11) step(6'b001_101, 1'b1, 1'b1,
                         ev(2'b00, 0, 0, 0, 0, 0, 0, 0, 3'd0, 1, 0, 6'd1), "halt");

        // Reset out of HALT
        pulse_reset();
        step(6'b001_101, 1'b0, 1'b0, ev(2'b11, 1, 0, 0, 0, 0, 0, 0, 3'd0, 0, 0, 6'd0),
             "post_halt_reset");

        @(negedge clk);
        #1;
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d pending required 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
